// File: rtl/endecoder_pkg.sv
// Shared types and constants for the endecoder stream driver and its environment.
package endecoder_pkg;

    localparam int unsigned NIBBLE_W = 4;
    localparam int unsigned BYTE_W   = 8;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START_LO,
        ST_WAIT_LO,
        ST_START_HI,
        ST_WAIT_HI,
        ST_OUT
    } drv_state_e;

endpackage

// File: rtl/endecoder_stream_driver_if.sv
// Byte stream, core handshake and status signals of the endecoder stream driver.
interface endecoder_stream_driver_if;
    import endecoder_pkg::*;

    logic [BYTE_W-1:0]   in_data_i;
    logic                in_valid_i;
    logic                in_ready_o;
    logic [NIBBLE_W-1:0] key_i;
    logic                mode_i;
    logic [NIBBLE_W-1:0] core_code_o;
    logic [NIBBLE_W-1:0] core_key_o;
    logic                core_mode_o;
    logic                core_start_o;
    logic [NIBBLE_W-1:0] core_code_i;
    logic                core_done_i;
    logic [BYTE_W-1:0]   out_data_o;
    logic                out_valid_o;
    logic                out_ready_i;
    logic                err_o;

    // Driver side
    modport slave (
        input  in_data_i, in_valid_i, key_i, mode_i, core_code_i, core_done_i, out_ready_i,
        output in_ready_o, core_code_o, core_key_o, core_mode_o, core_start_o,
        output out_data_o, out_valid_o, err_o
    );

    // Environment side: byte source/sink and the core
    modport master (
        output in_data_i, in_valid_i, key_i, mode_i, core_code_i, core_done_i, out_ready_i,
        input  in_ready_o, core_code_o, core_key_o, core_mode_o, core_start_o,
        input  out_data_o, out_valid_o, err_o
    );

endinterface

// File: rtl/endecoder_watchdog.sv
// Per-nibble watchdog: cleared on each start, counts WAIT cycles without done.
module endecoder_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned CNT_W          = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_c
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            r_cnt <= '0;
        end else if (en_i) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Fires in the cycle whose increment lands the count on TIMEOUT_CYCLES-1
    assign expired_c = en_i && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 2));

endmodule

// File: rtl/endecoder_stream_driver.sv
// Splits each input byte into two nibbles, runs each through the core via start/done,
// and reassembles the results into an output byte; a watchdog aborts a stuck core.
module endecoder_stream_driver
    import endecoder_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned CNT_W          = 8
) (
    input logic                      clk_i,
    input logic                      rst_i,
    endecoder_stream_driver_if.slave bus
);

    drv_state_e          r_state;
    drv_state_e          w_next_state;
    logic [NIBBLE_W-1:0] r_hi_nib;
    logic [NIBBLE_W-1:0] r_lo_res;
    logic                r_in_ready;
    logic [NIBBLE_W-1:0] r_core_code;
    logic [NIBBLE_W-1:0] r_core_key;
    logic                r_core_mode;
    logic                r_core_start;
    logic [BYTE_W-1:0]   r_out_data;
    logic                r_out_valid;
    logic                r_err;

    logic                w_accept;
    logic                w_cap_lo;
    logic                w_cap_hi;
    logic                w_set_err;
    logic                w_wd_clr;
    logic                w_wd_en;
    logic                w_wd_expired;
    logic [NIBBLE_W-1:0] w_core_code;

    endecoder_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_watchdog (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (w_wd_clr),
        .en_i      (w_wd_en),
        .expired_c (w_wd_expired)
    );

    // Next state and datapath controls; done takes priority over watchdog expiry
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_cap_lo     = 1'b0;
        w_cap_hi     = 1'b0;
        w_set_err    = 1'b0;
        w_wd_clr     = 1'b0;
        w_wd_en      = 1'b0;
        w_core_code  = r_core_code;
        case (r_state)
            ST_IDLE: begin
                if (bus.in_valid_i) begin
                    w_accept     = 1'b1;
                    w_core_code  = bus.in_data_i[NIBBLE_W-1:0];
                    w_next_state = ST_START_LO;
                end
            end
            ST_START_LO: begin
                w_wd_clr     = 1'b1;
                w_next_state = ST_WAIT_LO;
            end
            ST_WAIT_LO: begin
                w_wd_en = !bus.core_done_i;
                if (bus.core_done_i) begin
                    w_cap_lo     = 1'b1;
                    w_core_code  = r_hi_nib;
                    w_next_state = ST_START_HI;
                end else if (w_wd_expired) begin
                    w_set_err    = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            ST_START_HI: begin
                w_wd_clr     = 1'b1;
                w_next_state = ST_WAIT_HI;
            end
            ST_WAIT_HI: begin
                w_wd_en = !bus.core_done_i;
                if (bus.core_done_i) begin
                    w_cap_hi     = 1'b1;
                    w_next_state = ST_OUT;
                end else if (w_wd_expired) begin
                    w_set_err    = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            ST_OUT: begin
                if (bus.out_ready_i) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // State and registered outputs, the latter derived from the upcoming state
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= ST_IDLE;
            r_hi_nib     <= '0;
            r_lo_res     <= '0;
            r_in_ready   <= 1'b1;
            r_core_code  <= '0;
            r_core_key   <= '0;
            r_core_mode  <= 1'b0;
            r_core_start <= 1'b0;
            r_out_data   <= '0;
            r_out_valid  <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_in_ready   <= (w_next_state == ST_IDLE);
            r_core_start <= (w_next_state == ST_START_LO) || (w_next_state == ST_START_HI);
            r_out_valid  <= (w_next_state == ST_OUT);
            r_core_code  <= w_core_code;
            r_err        <= r_err | w_set_err;
            if (w_accept) begin
                r_hi_nib    <= bus.in_data_i[BYTE_W-1:NIBBLE_W];
                r_core_key  <= bus.key_i;
                r_core_mode <= bus.mode_i;
            end
            if (w_cap_lo) begin
                r_lo_res <= bus.core_code_i;
            end
            if (w_cap_hi) begin
                r_out_data <= {bus.core_code_i, r_lo_res};
            end
        end
    end

    assign bus.in_ready_o   = r_in_ready;
    assign bus.core_code_o  = r_core_code;
    assign bus.core_key_o   = r_core_key;
    assign bus.core_mode_o  = r_core_mode;
    assign bus.core_start_o = r_core_start;
    assign bus.out_data_o   = r_out_data;
    assign bus.out_valid_o  = r_out_valid;
    assign bus.err_o        = r_err;

endmodule

// File: tb/tb_endecoder_stream_driver.sv
// Self-checking bench for endecoder_stream_driver with an XOR core stub of programmable latency.
module tb_endecoder_stream_driver;
    import endecoder_pkg::*;

    localparam int unsigned TIMEOUT = 8;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_err;
    int   core_lat;
    int   core_cnt;
    int   n_start;

    logic [3:0] st_code[$];
    logic [3:0] st_key[$];
    logic       st_mode[$];

    endecoder_stream_driver_if bus ();

    endecoder_stream_driver #(
        .TIMEOUT_CYCLES (TIMEOUT),
        .CNT_W          (8)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core stub: result = code ^ key, done in the core_lat-th cycle after start (0 = never)
    always @(posedge clk) begin
        if (rst) core_cnt <= 0;
        else if (bus.core_start_o) core_cnt <= core_lat;
        else if (core_cnt > 0) core_cnt <= core_cnt - 1;
    end
    assign bus.core_done_i = (core_cnt == 1);
    assign bus.core_code_i = bus.core_code_o ^ bus.core_key_o;

    always @(posedge clk) begin
        if (!rst && bus.core_start_o) begin
            n_start++;
            st_code.push_back(bus.core_code_o);
            st_key.push_back(bus.core_key_o);
            st_mode.push_back(bus.core_mode_o);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a byte, wait for acceptance; returns in the START_LO cycle
    task automatic send(input logic [7:0] b, input logic [3:0] k, input logic m);
        bus.in_data_i  = b;
        bus.key_i      = k;
        bus.mode_i     = m;
        bus.in_valid_i = 1'b1;
        for (int i = 0; i < 40 && !bus.in_ready_o; i++) step();
        chk("accept_ready", bus.in_ready_o, 1'b1);
        step();
        bus.in_valid_i = 1'b0;
    endtask

    task automatic wait_out();
        for (int i = 0; i < 80 && !bus.out_valid_o; i++) step();
        chk("out_seen", bus.out_valid_o, 1'b1);
    endtask

    initial begin
        logic [7:0] d;
        logic [3:0] k;
        logic       m;
        logic [7:0] obs;
        logic       acc;
        logic       hs;
        logic       saw;
        int         base;
        int         idx;
        int         n_got;
        int         n_sent;
        logic [7:0] q[$];

        n_checks = 0;
        n_err    = 0;
        n_start  = 0;
        core_lat = 2;
        rst      = 1'b1;
        bus.in_data_i  = '0;
        bus.in_valid_i = 1'b0;
        bus.key_i      = '0;
        bus.mode_i     = MODE_ENC;
        bus.out_ready_i = 1'b1;
        step();
        step();
        chk("rst_in_ready", bus.in_ready_o, 1'b1);
        chk("rst_start", bus.core_start_o, 1'b0);
        chk("rst_code", bus.core_code_o, 4'h0);
        chk("rst_key", bus.core_key_o, 4'h0);
        chk("rst_mode", bus.core_mode_o, 1'b0);
        chk("rst_out_data", bus.out_data_o, 8'h00);
        chk("rst_out_valid", bus.out_valid_o, 1'b0);
        chk("rst_err", bus.err_o, 1'b0);
        rst = 1'b0;
        step();

        // Basic byte: 3C with key A, two-cycle core
        base = st_code.size();
        send(8'h3C, 4'hA, MODE_ENC);
        chk("t1_start_lo", bus.core_start_o, 1'b1);
        chk("t1_code_lo", bus.core_code_o, 4'hC);
        chk("t1_busy", bus.in_ready_o, 1'b0);
        repeat (3) step();
        chk("t1_start_hi", bus.core_start_o, 1'b1);
        chk("t1_code_hi", bus.core_code_o, 4'h3);
        repeat (2) step();
        chk("t1_no_early_valid", bus.out_valid_o, 1'b0);
        step();
        chk("t1_valid_c7", bus.out_valid_o, 1'b1);
        chk("t1_data", bus.out_data_o, 8'h96);
        chk("t1_err", bus.err_o, 1'b0);
        step();
        chk("t1_valid_drop", bus.out_valid_o, 1'b0);
        chk("t1_ready_back", bus.in_ready_o, 1'b1);
        chk("t1_nstarts", st_code.size() - base, 2);

        // Done arriving in the last allowed WAIT cycle wins over the watchdog
        core_lat = int'(TIMEOUT) - 1;
        send(8'h6B, 4'h2, MODE_DEC);
        wait_out();
        chk("edge_data", bus.out_data_o, 8'h49);
        chk("edge_err", bus.err_o, 1'b0);
        step();
        core_lat = 2;

        // Backpressure
        bus.out_ready_i = 1'b0;
        send(8'hF0, 4'h5, MODE_ENC);
        repeat (6) step();
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", bus.out_valid_o, 1'b1);
            chk("bp_data", bus.out_data_o, 8'hA5);
            chk("bp_ready", bus.in_ready_o, 1'b0);
            step();
        end
        bus.out_ready_i = 1'b1;
        step();
        chk("bp_released", bus.out_valid_o, 1'b0);
        chk("bp_idle", bus.in_ready_o, 1'b1);

        // Stuck core: err appears 8 cycles after the START_LO pulse
        core_lat = 0;
        send(8'h55, 4'h3, MODE_ENC);
        saw = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step();
            if (bus.out_valid_o) saw = 1'b1;
        end
        chk("stuck_err_early", bus.err_o, 1'b0);
        chk("stuck_busy", bus.in_ready_o, 1'b0);
        step();
        chk("stuck_err", bus.err_o, 1'b1);
        chk("stuck_ready", bus.in_ready_o, 1'b1);
        chk("stuck_no_out", saw || bus.out_valid_o, 1'b0);
        core_lat = 2;
        send(8'h12, 4'h0, MODE_ENC);
        wait_out();
        chk("post_err_data", bus.out_data_o, 8'h12);
        chk("post_err_sticky", bus.err_o, 1'b1);
        step();

        // Key/mode changes after acceptance must not reach the core
        base = st_code.size();
        send(8'h5E, 4'h1, MODE_ENC);
        bus.key_i  = 4'hF;
        bus.mode_i = MODE_DEC;
        wait_out();
        chk("key_data", bus.out_data_o, 8'h4F);
        chk("key_lo", st_key[base], 4'h1);
        chk("key_hi", st_key[base+1], 4'h1);
        chk("mode_lo", st_mode[base], MODE_ENC);
        chk("mode_hi", st_mode[base+1], MODE_ENC);
        chk("code_lo", st_code[base], 4'hE);
        chk("code_hi", st_code[base+1], 4'h5);
        step();

        // Reset in WAIT_HI discards the byte and clears err
        core_lat = 3;
        send(8'h9A, 4'h6, MODE_DEC);
        repeat (4) step();
        chk("rst_mid_start_hi", bus.core_start_o, 1'b1);
        chk("rst_mid_code_hi", bus.core_code_o, 4'h9);
        step();
        rst = 1'b1;
        step();
        chk("rstm_in_ready", bus.in_ready_o, 1'b1);
        chk("rstm_start", bus.core_start_o, 1'b0);
        chk("rstm_code", bus.core_code_o, 4'h0);
        chk("rstm_key", bus.core_key_o, 4'h0);
        chk("rstm_mode", bus.core_mode_o, 1'b0);
        chk("rstm_out_data", bus.out_data_o, 8'h00);
        chk("rstm_out_valid", bus.out_valid_o, 1'b0);
        chk("rstm_err", bus.err_o, 1'b0);
        rst = 1'b0;
        saw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.out_valid_o) saw = 1'b1;
        end
        chk("rstm_no_out", saw, 1'b0);

        // Back-to-back 00..FF with key A
        core_lat = 2;
        base = n_start;
        idx = 0;
        n_got = 0;
        q.delete();
        bus.key_i = 4'hA;
        bus.mode_i = MODE_ENC;
        bus.in_data_i = 8'h00;
        bus.in_valid_i = 1'b1;
        for (int cyc = 0; cyc < 4000 && n_got < 256; cyc++) begin
            acc = bus.in_valid_i && bus.in_ready_o;
            hs  = bus.out_valid_o && bus.out_ready_i;
            obs = bus.out_data_o;
            step();
            if (acc) begin
                q.push_back(8'(idx) ^ 8'hAA);
                idx++;
                if (idx < 256) bus.in_data_i = 8'(idx);
                else bus.in_valid_i = 1'b0;
            end
            if (hs) begin
                chk("b2b_out", obs, q.pop_front());
                n_got++;
            end
        end
        bus.in_valid_i = 1'b0;
        chk("b2b_count", n_got, 256);
        chk("b2b_starts", n_start - base, 512);
        chk("b2b_err", bus.err_o, 1'b0);

        // Random bytes, keys, modes, core latencies and backpressure
        n_got = 0;
        n_sent = 0;
        q.delete();
        d = '0;
        k = '0;
        for (int cyc = 0; cyc < 6000 && n_got < 40; cyc++) begin
            bus.out_ready_i = 1'($urandom_range(0, 1));
            core_lat = int'($urandom_range(1, TIMEOUT - 1));
            if (!bus.in_valid_i && n_sent < 40 && $urandom_range(0, 1) == 1) begin
                d = 8'($urandom);
                k = 4'($urandom);
                m = 1'($urandom_range(0, 1));
                bus.in_data_i  = d;
                bus.key_i      = k;
                bus.mode_i     = m;
                bus.in_valid_i = 1'b1;
            end
            acc = bus.in_valid_i && bus.in_ready_o;
            hs  = bus.out_valid_o && bus.out_ready_i;
            obs = bus.out_data_o;
            step();
            if (acc) begin
                q.push_back({d[7:4] ^ k, d[3:0] ^ k});
                n_sent++;
                bus.in_valid_i = 1'b0;
            end
            if (hs) begin
                chk("rand_out", obs, q.pop_front());
                n_got++;
            end
        end
        chk("rand_count", n_got, 40);
        chk("rand_err", bus.err_o, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/endecoder_stream_driver.md
Name: endecoder_stream_driver

Overview:
Initiator side of the endecoder core's start/done handshake. It accepts bytes from an upstream valid/ready stream and splits each byte into two nibbles, low nibble first. For each nibble it issues one start pulse to the core with the latched key and mode, waits for done, captures the result, and reassembles the two results into an output byte on a downstream valid/ready stream. It sits between the chip-level byte interface and endecoder_core, and carries a watchdog against a core that never signals done.

Parameters:
TIMEOUT_CYCLES, 64, maximum number of WAIT-state cycles per nibble before the transaction aborts; legal range 2..2**CNT_W-1.
CNT_W, 8, width of the watchdog counter.

Ports:
clk_i  in  1  system clock; all logic on the rising edge.
rst_i  in  1  synchronous, active-high reset.
in_data_i  in  8  upstream byte.
in_valid_i  in  1  upstream byte valid.
in_ready_o  out  1  driver can accept a byte.
key_i  in  4  key, sampled on byte acceptance.
mode_i  in  1  0 = encrypt, 1 = decrypt; sampled on byte acceptance.
core_code_o  out  4  nibble to core.
core_key_o  out  4  latched key to core.
core_mode_o  out  1  latched mode to core.
core_start_o  out  1  one-cycle start pulse to core.
core_code_i  in  4  core result.
core_done_i  in  1  core completion.
out_data_o  out  8  reassembled byte: {hi_result, lo_result}.
out_valid_o  out  1  output byte valid.
out_ready_i  in  1  downstream accepts the byte.
err_o  out  1  sticky timeout flag; cleared only by rst_i.

Behaviour:
- One clock (clk_i). Reset is synchronous and active-high (rst_i). The polarity and synchronicity are fixed.
- Reset values: state = IDLE; in_ready_o = 1; core_start_o = 0; core_code_o, core_key_o, core_mode_o = 0; out_data_o = 0; out_valid_o = 0; err_o = 0; watchdog = 0.
- A reset asserted mid-transaction discards any partial byte with no output. The driver is in IDLE on the first cycle after reset is released.
- States: IDLE, START_LO, WAIT_LO, START_HI, WAIT_HI, OUT.
- IDLE:
  - in_ready_o = 1, and only in this state.
  - On in_valid_i, latch in_data_i, key_i and mode_i, then go to START_LO.
- START_LO:
  - core_code_o = byte[3:0]; core_start_o = 1 for exactly this cycle.
  - Clear the watchdog and go to WAIT_LO.
- WAIT_LO:
  - core_done_i is sampled only in WAIT states.
  - On core_done_i = 1, capture core_code_i into lo_result and go to START_HI.
  - Otherwise increment the watchdog. When the watchdog reaches TIMEOUT_CYCLES-1 without done, set err_o, drop the byte and go to IDLE.
  - If done arrives in the same cycle the watchdog reaches its limit, done wins.
- START_HI / WAIT_HI: same as the LO states, using byte[7:4] and capturing into hi_result. On done, go to OUT.
- OUT:
  - out_valid_o = 1 and out_data_o = {hi_result, lo_result}.
  - Both are held stable until out_ready_i = 1, then go to IDLE.
  - There is no bypass: the next byte is accepted at the earliest on the cycle after the handshake.
- core_key_o, core_code_o and core_mode_o hold their values from START through WAIT.
- Core contract: core_done_i is low in the cycle after a start pulse unless the result is already valid. Minimum per-nibble latency is 1 cycle (done in the first WAIT cycle).
- Byte latency, acceptance to out_valid_o = 2*(1 + Lcore) + 1 cycles, where Lcore is the number of WAIT cycles.
- err_o does not block operation: later bytes are processed normally.

Decomposition:
- Package endecoder_pkg holds:
  - the driver state enum;
  - NIBBLE_W = 4 and BYTE_W = 8;
  - MODE_ENC = 0 and MODE_DEC = 1.
- Sub-module endecoder_watchdog is natural: a counter with clear, enable and expiry output, parameterised by TIMEOUT_CYCLES and CNT_W.
- FSM and datapath remain in endecoder_stream_driver.

Test Plan:
- The bench core model returns code ^ key with done 2 cycles after start. Stimulus: key = 4'hA, mode = 0, byte 8'h3C, out_ready_i = 1. Required: start pulses carry nibbles 4'hC then 4'h3; out_data_o = 8'h96 on cycle 7 after acceptance; err_o = 0.
- Backpressure: out_ready_i = 0 for 10 cycles with byte 8'hF0, key 4'h5. Required: out_valid_o held with out_data_o = 8'hA5 stable; in_ready_o = 0 throughout; the byte completes when out_ready_i rises.
- Stuck core: core model never asserts done, TIMEOUT_CYCLES = 8. Required: err_o rises 8 cycles after the START_LO pulse; no output; in_ready_o = 1 on the next cycle. A following byte 8'h12 with key 4'h0 yields 8'h12 and err_o stays 1.
- Change key_i and mode_i mid-transaction (4'h1 to 4'hF). Required: core_key_o stays at the latched 4'h1 for both nibbles.
- Assert rst_i during WAIT_HI. Required: next cycle all outputs are at reset values and err_o = 0; no output byte is produced.
- Back-to-back bytes 8'h00 through 8'hFF with in_valid_i always high. Required: all 256 outputs in order, each equal to the byte XOR 8'hAA with key 4'hA; exactly one start per nibble.
